// File: rtl/phase_sequencer_if.sv
// Control/actuator bundle of the N-phase sequencer: the control-register
// block drives the master side, the sequencer sits on the slave side.
interface phase_sequencer_if #(
  parameter int NUM_PHASES = 3,
  parameter int DUR_W      = 8,
  parameter int OUT_W      = 2,
  parameter int CNT_W      = 8
);
  localparam int IDX_W = $clog2(NUM_PHASES);

  logic                        enable;
  logic                        continuous;
  logic                        pause;
  logic                        abort;
  logic [NUM_PHASES*DUR_W-1:0] durations;
  logic [NUM_PHASES*OUT_W-1:0] phase_masks;
  logic [OUT_W-1:0]            actuators;
  logic [IDX_W-1:0]            phase_idx;
  logic                        busy;
  logic                        done;
  logic                        cycle_done;
  logic [CNT_W-1:0]            cycle_count;

  modport master (
    output enable, continuous, pause, abort, durations, phase_masks,
    input  actuators, phase_idx, busy, done, cycle_done, cycle_count
  );

  modport slave (
    input  enable, continuous, pause, abort, durations, phase_masks,
    output actuators, phase_idx, busy, done, cycle_done, cycle_count
  );
endinterface

// File: rtl/phase_sequencer.sv
// N-phase timed actuator sequencer: per-phase durations and actuator masks,
// zero-duration skip, repeat mode, pause and abort; Moore outputs.
module phase_sequencer #(
  parameter int NUM_PHASES = 3,
  parameter int DUR_W      = 8,
  parameter int OUT_W      = 2,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  phase_sequencer_if.slave   bus
);
  localparam int IDX_W = $clog2(NUM_PHASES);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_END} state_t;

  state_t           state, state_n;
  logic [DUR_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] ccount, ccount_n;
  logic             cdone, cdone_n;
  logic [DUR_W-1:0] lat_dur   [NUM_PHASES];
  logic [DUR_W-1:0] lat_dur_n [NUM_PHASES];
  logic [OUT_W-1:0] lat_msk   [NUM_PHASES];
  logic [OUT_W-1:0] lat_msk_n [NUM_PHASES];

  logic             start_found, next_found;
  logic [IDX_W-1:0] start_idx, next_idx;
  logic [DUR_W-1:0] cur_dur;

  // First nonzero phase of the live inputs (used at start and on wrap) and
  // next nonzero phase after idx within the latched set.
  always_comb begin
    start_found = 1'b0;
    start_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if (!start_found && bus.durations[i*DUR_W +: DUR_W] != '0) begin
        start_found = 1'b1;
        start_idx   = IDX_W'(i);
      end
      if (!next_found && i > 32'(idx) && lat_dur[i] != '0) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(i);
      end
    end
    cur_dur = lat_dur[idx];
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    ccount_n  = ccount;
    cdone_n   = 1'b0;
    lat_dur_n = lat_dur;
    lat_msk_n = lat_msk;

    case (state)
      ST_IDLE: begin
        if (!bus.abort && bus.enable) begin
          for (int unsigned i = 0; i < NUM_PHASES; i++) begin
            lat_dur_n[i] = bus.durations[i*DUR_W +: DUR_W];
            lat_msk_n[i] = bus.phase_masks[i*OUT_W +: OUT_W];
          end
          cnt_n    = '0;
          ccount_n = '0;
          if (start_found) begin
            state_n = ST_RUN;
            idx_n   = start_idx;
          end else begin
            state_n = ST_END;
            idx_n   = '0;
          end
        end
      end

      ST_RUN: begin
        if (bus.abort) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end else if (bus.pause) begin
          state_n = ST_PAUSED;
        end else if (cnt == cur_dur - DUR_W'(1)) begin
          cnt_n = '0;
          if (next_found) begin
            idx_n = next_idx;
          end else begin
            // End of pass: count it, then wrap with fresh settings or stop.
            cdone_n  = 1'b1;
            ccount_n = (ccount == '1) ? ccount : ccount + CNT_W'(1);
            idx_n    = '0;
            state_n  = ST_END;
            if (bus.continuous) begin
              for (int unsigned i = 0; i < NUM_PHASES; i++) begin
                lat_dur_n[i] = bus.durations[i*DUR_W +: DUR_W];
                lat_msk_n[i] = bus.phase_masks[i*OUT_W +: OUT_W];
              end
              if (start_found) begin
                state_n = ST_RUN;
                idx_n   = start_idx;
              end
            end
          end
        end else begin
          cnt_n = cnt + DUR_W'(1);
        end
      end

      ST_PAUSED: begin
        if (bus.abort) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end else if (!bus.pause) begin
          state_n = ST_RUN;
        end
      end

      ST_END: begin
        if (bus.abort || !bus.enable) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      ccount  <= '0;
      cdone   <= 1'b0;
      lat_dur <= '{default: '0};
      lat_msk <= '{default: '0};
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      ccount  <= ccount_n;
      cdone   <= cdone_n;
      lat_dur <= lat_dur_n;
      lat_msk <= lat_msk_n;
    end
  end

  always_comb begin
    bus.actuators   = (state == ST_RUN) ? lat_msk[idx] : '0;
    bus.phase_idx   = (state == ST_RUN || state == ST_PAUSED) ? idx : '0;
    bus.busy        = (state == ST_RUN || state == ST_PAUSED);
    bus.done        = (state == ST_END);
    bus.cycle_done  = cdone;
    bus.cycle_count = ccount;
  end
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: vector table for whole passes plus
// hand-written pause, abort, reset and counter-saturation sequences.
module tb_phase_sequencer;
  localparam int NP = 3;
  localparam int DW = 8;
  localparam int OW = 2;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  phase_sequencer_if #(.NUM_PHASES(NP), .DUR_W(DW), .OUT_W(OW), .CNT_W(CW)) bus ();
  phase_sequencer #(.NUM_PHASES(NP), .DUR_W(DW), .OUT_W(OW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  phase_sequencer_if #(.NUM_PHASES(NP), .DUR_W(DW), .OUT_W(OW), .CNT_W(2)) sbus ();
  phase_sequencer #(.NUM_PHASES(NP), .DUR_W(DW), .OUT_W(OW), .CNT_W(2)) sdut (
    .clk(clk), .reset_n(reset_n), .bus(sbus)
  );

  typedef struct {
    logic        en, co, pa, ab;
    logic [23:0] du;
    logic [5:0]  ms;
    logic [1:0]  act, idx;
    logic        busy, done, cd;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vq[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, co, pa, ab, input logic [23:0] du, input logic [5:0] ms);
    bus.enable      = en;
    bus.continuous  = co;
    bus.pause       = pa;
    bus.abort       = ab;
    bus.durations   = du;
    bus.phase_masks = ms;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] act, idx,
                            input logic busy, done, cd, input logic [7:0] cnt);
    chk({tag, ".act"},  32'(bus.actuators),   32'(act));
    chk({tag, ".idx"},  32'(bus.phase_idx),   32'(idx));
    chk({tag, ".busy"}, 32'(bus.busy),        32'(busy));
    chk({tag, ".done"}, 32'(bus.done),        32'(done));
    chk({tag, ".cd"},   32'(bus.cycle_done),  32'(cd));
    chk({tag, ".cnt"},  32'(bus.cycle_count), 32'(cnt));
  endtask

  task automatic add(input logic en, co, pa, ab, input logic [23:0] du, input logic [5:0] ms,
                     input logic [1:0] act, idx, input logic busy, done, cd, input logic [7:0] cnt);
    vec_t v;
    v = '{en, co, pa, ab, du, ms, act, idx, busy, done, cd, cnt};
    vq.push_back(v);
  endtask

  // Phase i occupies bits [i*8 +: 8] of durations and [i*2 +: 2] of masks.
  localparam logic [23:0] D1 = 24'h040203;  // {3,2,4}
  localparam logic [5:0]  M1 = 6'b100001;   // {01,00,10}
  localparam logic [23:0] D2 = 24'h000500;  // {0,5,0}
  localparam logic [5:0]  M2 = 6'b001100;
  localparam logic [23:0] D3 = 24'h010101;  // {1,1,1}
  localparam logic [23:0] D4 = 24'h010102;  // {2,1,1}
  localparam logic [5:0]  M3 = 6'b111001;   // {01,10,11}
  localparam logic [23:0] D5 = 24'h000203;  // {3,2,0}
  localparam logic [5:0]  M5 = 6'b001001;   // {01,10,00}
  localparam logic [23:0] D6 = 24'h010001;  // {1,0,1}
  localparam logic [5:0]  M6 = 6'b100001;

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, '0, '0);
    sbus.enable = 1'b0; sbus.continuous = 1'b0; sbus.pause = 1'b0; sbus.abort = 1'b0;
    sbus.durations = '0; sbus.phase_masks = '0;
    tick(); tick();
    expect_out("reset", 2'b00, 0, 0, 0, 0, 0);
    chk("reset.sat_cnt", 32'(sbus.cycle_count), 0);
    reset_n = 1'b1;
    tick();
    expect_out("idle", 2'b00, 0, 0, 0, 0, 0);

    // Basic pass {3,2,4}
    add(1,0,0,0,D1,M1, 2'b01,0,1,0,0,0);
    add(1,0,0,0,D1,M1, 2'b01,0,1,0,0,0);
    add(1,0,0,0,D1,M1, 2'b01,0,1,0,0,0);
    add(1,0,0,0,D1,M1, 2'b00,1,1,0,0,0);
    add(1,0,0,0,D1,M1, 2'b00,1,1,0,0,0);
    for (int i = 0; i < 4; i++) add(1,0,0,0,D1,M1, 2'b10,2,1,0,0,0);
    add(1,0,0,0,D1,M1, 2'b00,0,0,1,1,1);
    add(1,0,0,0,D1,M1, 2'b00,0,0,1,0,1);
    add(0,0,0,0,D1,M1, 2'b00,0,0,0,0,1);
    // Zero skip, then all-zero durations
    for (int i = 0; i < 5; i++) add(1,1,0,0,D2,M2, 2'b11,1,1,0,0,0);
    add(1,0,0,0,D2,M2, 2'b00,0,0,1,1,1);
    add(0,0,0,0,D2,M2, 2'b00,0,0,0,0,1);
    add(1,1,0,0,'0,M2, 2'b00,0,0,1,0,0);
    add(0,0,0,0,'0,M2, 2'b00,0,0,0,0,0);
    // Continuous; durations changed mid-pass apply only after the wrap
    add(1,1,0,0,D3,M3, 2'b01,0,1,0,0,0);
    add(1,1,0,0,D3,M3, 2'b10,1,1,0,0,0);
    add(1,1,0,0,D3,M3, 2'b11,2,1,0,0,0);
    add(1,1,0,0,D3,M3, 2'b01,0,1,0,1,1);
    add(1,1,0,0,D4,M3, 2'b10,1,1,0,0,1);
    add(1,1,0,0,D4,M3, 2'b11,2,1,0,0,1);
    add(1,1,0,0,D4,M3, 2'b01,0,1,0,1,2);
    add(1,0,0,0,D4,M3, 2'b01,0,1,0,0,2);
    add(1,0,0,0,D4,M3, 2'b10,1,1,0,0,2);
    add(1,0,0,0,D4,M3, 2'b11,2,1,0,0,2);
    add(1,0,0,0,D4,M3, 2'b00,0,0,1,1,3);
    add(0,0,0,0,D4,M3, 2'b00,0,0,0,0,3);

    foreach (vq[k]) begin
      drive(vq[k].en, vq[k].co, vq[k].pa, vq[k].ab, vq[k].du, vq[k].ms);
      tick();
      expect_out($sformatf("v%0d", k), vq[k].act, vq[k].idx, vq[k].busy,
                 vq[k].done, vq[k].cd, vq[k].cnt);
    end

    // Pause for 4 cycles with phase 0 at counter 1
    drive(1,0,0,0,D5,M5); tick(); expect_out("p.c0", 2'b01,0,1,0,0,0);
    tick();                       expect_out("p.c1", 2'b01,0,1,0,0,0);
    bus.pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); expect_out($sformatf("p.hold%0d", i), 2'b00,0,1,0,0,0);
    end
    bus.pause = 1'b0;
    tick(); expect_out("p.res_c1", 2'b01,0,1,0,0,0);
    tick(); expect_out("p.res_c2", 2'b01,0,1,0,0,0);
    tick(); expect_out("p.ph1_c0", 2'b10,1,1,0,0,0);
    tick(); expect_out("p.ph1_c1", 2'b10,1,1,0,0,0);
    // Pause in the phase-end cycle defers the transition
    bus.pause = 1'b1;
    tick(); expect_out("pe.hold", 2'b00,1,1,0,0,0);
    bus.pause = 1'b0;
    tick(); expect_out("pe.resume", 2'b10,1,1,0,0,0);
    tick(); expect_out("pe.end", 2'b00,0,0,1,1,1);
    bus.enable = 1'b0; tick(); expect_out("pe.idle", 2'b00,0,0,0,0,1);

    // Abort from RUN, in IDLE (blocks start), from PAUSED and from END
    drive(1,0,0,0,D5,M5); tick(); expect_out("a.run", 2'b01,0,1,0,0,0);
    bus.abort = 1'b1;     tick(); expect_out("a.run_ab", 2'b00,0,0,0,0,0);
    tick();                       expect_out("a.idle_block", 2'b00,0,0,0,0,0);
    bus.abort = 1'b0;     tick(); expect_out("a.start", 2'b01,0,1,0,0,0);
    bus.pause = 1'b1;     tick(); expect_out("a.paused", 2'b00,0,1,0,0,0);
    bus.abort = 1'b1;     tick(); expect_out("a.paused_ab", 2'b00,0,0,0,0,0);
    drive(1,0,0,0,D5,M5); tick(); expect_out("a.start2", 2'b01,0,1,0,0,0);
    for (int i = 0; i < 4; i++) tick();
    tick(); expect_out("a.end", 2'b00,0,0,1,1,1);
    bus.abort = 1'b1; tick(); expect_out("a.end_ab", 2'b00,0,0,0,0,1);
    drive(0,0,0,0,D5,M5); tick();

    // Synchronous reset mid-RUN
    drive(1,0,0,0,D5,M5); tick(); tick();
    reset_n = 1'b0;
    #2;
    expect_out("r.noedge", 2'b01,0,1,0,0,0);
    tick();
    expect_out("r.edge", 2'b00,0,0,0,0,0);
    reset_n = 1'b1;
    drive(0,0,0,0,'0,'0); tick();

    // Saturating 2-bit pass counter over 5 continuous passes of {1,0,1}
    sbus.durations = D6; sbus.phase_masks = M6; sbus.continuous = 1'b1; sbus.enable = 1'b1;
    tick();
    chk("s.start_act", 32'(sbus.actuators), 32'(2'b01));
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("s.p%0d_idx", k), 32'(sbus.phase_idx), 2);
      chk($sformatf("s.p%0d_cd0", k), 32'(sbus.cycle_done), 0);
      if (k == 5) sbus.continuous = 1'b0;
      tick();
      chk($sformatf("s.p%0d_cd", k), 32'(sbus.cycle_done), 1);
      chk($sformatf("s.p%0d_cnt", k), 32'(sbus.cycle_count), (k > 3) ? 3 : k);
    end
    chk("s.end_done", 32'(sbus.done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
